// File: rtl/dpram_initiator_if.sv
// dpram_initiator_if: RD/WR/Done request bus between the memory self-test
// initiator and the dual-port RAM controller.
//
// Handshake: the master raises exactly one of RD/WR and holds it, together
// with A (and DIn for a write), unchanged until it samples Done=1 on a rising
// edge; the request then drops on that same edge. Done is a one-cycle strobe
// from the slave. For a read, DOut is valid in the cycle Done=1.
//
// Signals:
//   RD, WR  master->slave  read / write request
//   A       master->slave  request address
//   DIn     master->slave  write data
//   DOut    slave->master  read data
//   Done    slave->master  request-complete strobe
interface dpram_initiator_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 16
);
  logic              RD;
  logic              WR;
  logic [ADDR_W-1:0] A;
  logic [DATA_W-1:0] DIn;
  logic [DATA_W-1:0] DOut;
  logic              Done;

  modport master (output RD, WR, A, DIn, input DOut, Done);
  modport slave  (input RD, WR, A, DIn, output DOut, Done);
endinterface

// File: rtl/dpram_initiator.sv
// dpram_initiator: built-in memory self-test master for the DPRAM controller.
// On start it writes pat(a) = SEED ^ rotl3(zero-extended a) to addresses
// 0..LAST_ADDR, then reads them back and compares, reporting pass/fail, the
// saturating mismatch count and the first failing address. A request that
// gets no Done within TIMEOUT cycles aborts the run with timeout/fail set.
//
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   start           begin a run (ignored while busy)
//   bus             master side of the RD/WR/Done request bus
//   busy            run in progress
//   pass, fail      result of the last completed run
//   timeout         last run aborted waiting for Done
//   err_count       mismatch count, saturates at 16'hFFFF
//   first_err_addr  address of the first mismatch
//   state_dbg       current FSM state: 0 IDLE, 1 WR_REQ, 2 WR_GAP,
//                   3 RD_REQ, 4 RD_GAP, 5 FIN
//
// Every output is a flop whose next value is computed from the next state,
// so a request rises on the same edge that enters WR_REQ/RD_REQ and drops on
// the edge that samples Done.
module dpram_initiator #(
  parameter int unsigned       ADDR_W    = 10,
  parameter int unsigned       DATA_W    = 16,
  parameter int unsigned       LAST_ADDR = 1023,
  parameter logic [DATA_W-1:0] SEED      = 16'hA5C3,
  parameter int unsigned       TIMEOUT   = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  dpram_initiator_if.master  bus,
  output logic               busy,
  output logic               pass,
  output logic               fail,
  output logic               timeout,
  output logic [15:0]        err_count,
  output logic [ADDR_W-1:0]  first_err_addr,
  output logic [2:0]         state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR_REQ = 3'd1,
    WR_GAP = 3'd2,
    RD_REQ = 3'd3,
    RD_GAP = 3'd4,
    FIN    = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_ADDR);
  localparam logic [15:0]       TO_LAST = 16'(TIMEOUT - 1);

  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] ext;
    ext = DATA_W'(a);
    return SEED ^ {ext[DATA_W-4:0], ext[DATA_W-1:DATA_W-3]};
  endfunction

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic [15:0]         wait_q, wait_d;
  logic [15:0]         err_q, err_d;
  logic [ADDR_W-1:0]   first_q, first_d;
  logic                rd_q, rd_d, wr_q, wr_d, busy_q, busy_d;
  logic                pass_q, pass_d, fail_q, fail_d, to_q, to_d;
  logic [ADDR_W-1:0]   a_inc;

  assign a_inc = a_q + 1'b1;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    din_d   = din_q;
    wait_d  = wait_q;
    err_d   = err_q;
    first_d = first_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    to_d    = to_q;
    case (state_q)
      IDLE, FIN: begin
        if (start) begin
          state_d = WR_REQ;
          a_d     = '0;
          din_d   = pat('0);
          wait_d  = '0;
          err_d   = '0;
          first_d = '0;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
          to_d    = 1'b0;
        end
      end
      WR_REQ: begin
        if (bus.Done) begin
          state_d = WR_GAP;
        end else if (wait_q == TO_LAST) begin
          // Abort: request drops, counters keep their values.
          state_d = FIN;
          to_d    = 1'b1;
          fail_d  = 1'b1;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      WR_GAP: begin
        wait_d = '0;
        if (a_q == LAST_A) begin
          state_d = RD_REQ;
          a_d     = '0;
        end else begin
          state_d = WR_REQ;
          a_d     = a_inc;
          din_d   = pat(a_inc);
        end
      end
      RD_REQ: begin
        if (bus.Done) begin
          state_d = RD_GAP;
          if (bus.DOut != pat(a_q)) begin
            if (err_q == 16'd0) first_d = a_q;
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
          end
        end else if (wait_q == TO_LAST) begin
          state_d = FIN;
          to_d    = 1'b1;
          fail_d  = 1'b1;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      RD_GAP: begin
        wait_d = '0;
        if (a_q == LAST_A) begin
          // err_q already includes the last compare (made on the Done edge).
          state_d = FIN;
          pass_d  = (err_q == 16'd0);
          fail_d  = (err_q != 16'd0);
        end else begin
          state_d = RD_REQ;
          a_d     = a_inc;
        end
      end
      default: state_d = IDLE;
    endcase
    wr_d   = (state_d == WR_REQ);
    rd_d   = (state_d == RD_REQ);
    busy_d = (state_d != IDLE) && (state_d != FIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      din_q   <= '0;
      wait_q  <= '0;
      err_q   <= '0;
      first_q <= '0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      to_q    <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      din_q   <= din_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      first_q <= first_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      to_q    <= to_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.RD         = rd_q;
  assign bus.WR         = wr_q;
  assign bus.A          = a_q;
  assign bus.DIn        = din_q;
  assign busy           = busy_q;
  assign pass           = pass_q;
  assign fail           = fail_q;
  assign timeout        = to_q;
  assign err_count      = err_q;
  assign first_err_addr = first_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_dpram_initiator.sv
// Bench for dpram_initiator with LAST_ADDR=3, TIMEOUT=4 and a one-cycle
// latency responder (Done the cycle after it first sees a request).
module tb_dpram_initiator;

  localparam int AW = 10;
  localparam int DW = 16;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_FIN  = 3'd5;

  typedef struct packed {
    logic          is_wr;
    logic [AW-1:0] a;
    logic [DW-1:0] din;
  } txn_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  dpram_initiator_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  logic          busy, pass, fail, timeout;
  logic [15:0]   err_count;
  logic [AW-1:0] first_err_addr;
  logic [2:0]    state_dbg;

  dpram_initiator #(
    .ADDR_W(AW), .DATA_W(DW), .LAST_ADDR(3), .SEED(16'hA5C3), .TIMEOUT(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .busy(busy), .pass(pass), .fail(fail), .timeout(timeout),
    .err_count(err_count), .first_err_addr(first_err_addr),
    .state_dbg(state_dbg)
  );

  // ---------------- responder ----------------
  logic          resp_en = 1'b1;
  logic          corrupt_en = 1'b0;
  logic [AW-1:0] corrupt_addr = '0;
  logic          done_force = 1'b0;
  logic          resp_done;
  logic [DW-1:0] resp_dout;
  logic [DW-1:0] mem [4];

  initial for (int i = 0; i < 4; i++) mem[i] = '0;

  always @(posedge clk) begin
    if (rst) begin
      resp_done <= 1'b0;
      resp_dout <= '0;
    end else begin
      resp_done <= resp_en && (bus.WR || bus.RD) && !resp_done;
      if (bus.WR && !resp_done) mem[bus.A[1:0]] <= bus.DIn;
      resp_dout <= (bus.RD && corrupt_en && bus.A == corrupt_addr) ? '0 : mem[bus.A[1:0]];
    end
  end

  assign bus.Done = resp_done | done_force;
  assign bus.DOut = resp_dout;

  // ---------------- bus monitor ----------------
  txn_t          obs_q[$];
  int            proto_err = 0;
  int            wr_cnt = 0;
  logic          wr_prev = 1'b0, rd_prev = 1'b0;
  logic [AW-1:0] a_prev = '0;
  logic [DW-1:0] din_prev = '0;

  always @(negedge clk) begin
    if (bus.RD && bus.WR) proto_err++;
    if ((bus.WR && wr_prev) || (bus.RD && rd_prev))
      if (bus.A != a_prev || bus.DIn != din_prev) proto_err++;
    if (bus.WR && !wr_prev) obs_q.push_back({1'b1, bus.A, bus.DIn});
    if (bus.RD && !rd_prev) obs_q.push_back({1'b0, bus.A, 16'h0000});
    if (bus.WR) wr_cnt++;
    wr_prev  = bus.WR;
    rd_prev  = bus.RD;
    a_prev   = bus.A;
    din_prev = bus.DIn;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass = 0;
  txn_t exp_txn [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_seq(input string tag);
    check({tag, "_txn_count"}, 32'(obs_q.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      if (i < obs_q.size())
        check($sformatf("%s_txn%0d", tag, i), 32'(obs_q[i]), 32'(exp_txn[i]));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_outs"},
          {bus.RD, bus.WR, bus.A, bus.DIn, busy, pass, fail, timeout}, 32'd0);
    check({tag, "_counts"}, 32'({err_count, first_err_addr}), 32'd0);
    check({tag, "_state"}, 32'(state_dbg), 32'(S_IDLE));
  endtask

  // Pulse start and count negedges until busy falls; mid_at>0 re-pulses start
  // during the run.
  task automatic run(input int mid_at, output int cycles);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 1;
    while (busy && cycles < 400) begin
      start = (cycles == mid_at);
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
  endtask

  // ---------------- test ----------------
  int cyc;
  int n;

  initial begin
    exp_txn[0] = '{1'b1, 10'd0, 16'hA5C3};
    exp_txn[1] = '{1'b1, 10'd1, 16'hA5CB};
    exp_txn[2] = '{1'b1, 10'd2, 16'hA5D3};
    exp_txn[3] = '{1'b1, 10'd3, 16'hA5DB};
    exp_txn[4] = '{1'b0, 10'd0, 16'h0000};
    exp_txn[5] = '{1'b0, 10'd1, 16'h0000};
    exp_txn[6] = '{1'b0, 10'd2, 16'h0000};
    exp_txn[7] = '{1'b0, 10'd3, 16'h0000};

    // Reset state.
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // rst together with start: rst wins.
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst_start_busy", 32'(busy), 32'd0);
    check("rst_start_state", 32'(state_dbg), 32'(S_IDLE));

    // Done pulsed while idle.
    done_force = 1'b1;
    @(negedge clk);
    done_force = 1'b0;
    @(negedge clk);
    check_idle_outputs("idle_done");

    // Clean run with a start pulse in the middle.
    obs_q.delete();
    run(5, cyc);
    check("clean_run_cycles", 32'(cyc), 32'd25);
    check_seq("clean");
    check("clean_pass", {pass, fail, timeout}, 32'b100);
    check("clean_err", 32'(err_count), 32'd0);
    check("clean_state", 32'(state_dbg), 32'(S_FIN));

    // Read of address 2 returns 0000.
    corrupt_en = 1'b1; corrupt_addr = 10'd2;
    obs_q.delete();
    run(0, cyc);
    corrupt_en = 1'b0;
    check("corrupt_run_cycles", 32'(cyc), 32'd25);
    check("corrupt_flags", {pass, fail, timeout}, 32'b010);
    check("corrupt_err", 32'(err_count), 32'd1);
    check("corrupt_first", 32'(first_err_addr), 32'd2);

    // Responder silent: write request must time out after 4 cycles.
    resp_en = 1'b0;
    wr_cnt = 0;
    run(0, cyc);
    repeat (3) @(negedge clk);
    resp_en = 1'b1;
    check("to_wr_cycles", 32'(wr_cnt), 32'd4);
    check("to_run_cycles", 32'(cyc), 32'd5);
    check("to_flags", {pass, fail, timeout, bus.WR, bus.RD}, 32'b01100);
    check("to_addr", 32'(bus.A), 32'd0);
    check("to_err_cleared", 32'(err_count), 32'd0);
    check("to_state", 32'(state_dbg), 32'(S_FIN));

    // Reset during the read of address 1.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(bus.RD && bus.A == 10'd1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reach_rd1", 32'(bus.RD && bus.A == 10'd1), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("mid_rst");
    rst = 1'b0;
    @(negedge clk);

    // Rerun after reset starts from address 0 and passes.
    obs_q.delete();
    run(0, cyc);
    check("rerun_cycles", 32'(cyc), 32'd25);
    check_seq("rerun");
    check("rerun_pass", {pass, fail, timeout}, 32'b100);
    check("rerun_err", 32'(err_count), 32'd0);

    check("protocol_violations", 32'(proto_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
